// File: rtl/gh_fifo_wr_arb4.sv
// rtl/gh_fifo_wr_arb4.sv - four-requester round-robin FIFO write-port arbiter
// Owner keeps the port for up to burst_len writes, then one idle cycle before the next grant.
module gh_fifo_wr_arb4 #(
  parameter int data_width = 8,
  parameter int burst_len  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              REQ,
  input  logic [4*data_width-1:0] D_IN,
  output logic [3:0]              ACK,
  output logic [3:0]              GNT,
  input  logic                    full,
  output logic                    WR,
  output logic [data_width-1:0]   D,
  output logic                    busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_nxt;
  logic [1:0] last, last_nxt;
  logic [3:0] gnt_nxt;
  logic [3:0] beat, beat_nxt;
  logic [1:0] pick, idx;
  logic       found;

  // In GRANT, last holds the current owner index.
  always_comb begin
    WR   = (state == GRANT) && REQ[last] && !full && !rst;
    ACK  = WR ? GNT : 4'b0000;
    busy = (state == GRANT);
    D    = (state == GRANT) ? D_IN[last*data_width +: data_width] : '0;
  end

  // Round-robin search starting one past the previous owner.
  always_comb begin
    pick  = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && REQ[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = GNT;
    last_nxt  = last;
    beat_nxt  = beat;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = GRANT;
          gnt_nxt   = 4'b0001 << pick;
          last_nxt  = pick;
          beat_nxt  = 4'd0;
        end
      end
      GRANT: begin
        if (!REQ[last]) begin
          state_nxt = IDLE;
          gnt_nxt   = 4'b0000;
        end else if (WR) begin
          beat_nxt = beat + 4'd1;
          if (beat + 4'd1 == 4'(burst_len)) begin
            state_nxt = IDLE;
            gnt_nxt   = 4'b0000;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      GNT   <= 4'b0000;
      beat  <= 4'd0;
      last  <= 2'd3;
    end else begin
      state <= state_nxt;
      GNT   <= gnt_nxt;
      beat  <= beat_nxt;
      last  <= last_nxt;
    end
  end

endmodule

// File: tb/tb_gh_fifo_wr_arb4.sv
// tb/tb_gh_fifo_wr_arb4.sv - directed-vector bench for gh_fifo_wr_arb4
// Instance u_dut uses burst_len 4; u_dut1 uses burst_len 1.
module tb_gh_fifo_wr_arb4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  REQ, REQ1;
  logic [31:0] D_IN;
  logic        full;
  logic [3:0]  ACK, GNT, ACK1, GNT1;
  logic        WR, WR1, busy, busy1;
  logic [7:0]  D, D1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gh_fifo_wr_arb4 #(.data_width(8), .burst_len(4)) u_dut (
    .clk(clk), .rst(rst), .REQ(REQ), .D_IN(D_IN), .ACK(ACK), .GNT(GNT),
    .full(full), .WR(WR), .D(D), .busy(busy)
  );

  gh_fifo_wr_arb4 #(.data_width(8), .burst_len(1)) u_dut1 (
    .clk(clk), .rst(rst), .REQ(REQ1), .D_IN(D_IN), .ACK(ACK1), .GNT(GNT1),
    .full(1'b0), .WR(WR1), .D(D1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] slice(input logic [3:0] g);
    case (g)
      4'b0001: slice = 8'hA0;
      4'b0010: slice = 8'hB1;
      4'b0100: slice = 8'hC2;
      4'b1000: slice = 8'hD3;
      default: slice = 8'h00;
    endcase
  endfunction

  // One clock of u_dut: drive, check at negedge, advance past the rising edge.
  task automatic cyc(input string tag, input logic r, input logic [3:0] req, input logic f,
                     input logic [3:0] eg, input logic ew);
    rst  = r;
    REQ  = req;
    full = f;
    @(negedge clk);
    chk({tag, ".GNT"},  32'(GNT),  32'(eg));
    chk({tag, ".WR"},   32'(WR),   32'(ew));
    chk({tag, ".ACK"},  32'(ACK),  32'(ew ? eg : 4'b0000));
    chk({tag, ".busy"}, 32'(busy), 32'(eg != 4'b0000));
    chk({tag, ".D"},    32'(D),    32'(slice(eg)));
    @(posedge clk);
    #1;
  endtask

  task automatic cyc1(input string tag, input logic [3:0] eg, input logic ew);
    REQ1 = 4'b0011;
    @(negedge clk);
    chk({tag, ".GNT"}, 32'(GNT1), 32'(eg));
    chk({tag, ".WR"},  32'(WR1),  32'(ew));
    chk({tag, ".ACK"}, 32'(ACK1), 32'(ew ? eg : 4'b0000));
    chk({tag, ".D"},   32'(D1),   32'(slice(eg)));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; REQ = 4'b0000; full = 1'b0;
    @(negedge clk);
    chk("rst.WR",  32'(WR),  32'd0);
    chk("rst.ACK", 32'(ACK), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    D_IN = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    REQ1 = 4'b0000;
    rst  = 1'b1; REQ = 4'b0001; full = 1'b0;
    @(posedge clk); #1;

    // single requester: 4 writes, one idle, re-grant
    cyc("a.rstw", 1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0);
    cyc("a.idle", 1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) cyc("a.wr", 1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1);
    cyc("a.gap",  1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0);
    cyc("a.rewr", 1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1);
    cyc("a.drop", 1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0);
    cyc("a.end",  1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

    // all four requesting: rotation 0,1,2,3,0
    do_reset();
    cyc("b.idle", 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0);
    for (int o = 0; o < 4; o++) begin
      for (int i = 0; i < 4; i++) cyc("b.wr", 1'b0, 4'b1111, 1'b0, 4'b0001 << o, 1'b1);
      cyc("b.gap", 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0);
    end
    cyc("b.wrap", 1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1);
    cyc("b.drop", 1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0);
    cyc("b.end",  1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

    // owner 2 stalled by full for 3 cycles; burst still totals exactly 4
    do_reset();
    cyc("c.idle", 1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 2; i++) cyc("c.wr",    1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1);
    for (int i = 0; i < 3; i++) cyc("c.stall", 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0);
    for (int i = 0; i < 2; i++) cyc("c.wr2",   1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1);
    cyc("c.rel", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0);

    // owner 1 drops after 2 writes, requester 3 pending; then rst mid-burst
    do_reset();
    cyc("d.idle", 1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 2; i++) cyc("d.wr", 1'b0, 4'b1010, 1'b0, 4'b0010, 1'b1);
    cyc("d.drop", 1'b0, 4'b1000, 1'b0, 4'b0010, 1'b0);
    cyc("d.gap",  1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0);
    cyc("e.b1",   1'b0, 4'b1000, 1'b0, 4'b1000, 1'b1);
    cyc("e.rst",  1'b1, 4'b1001, 1'b0, 4'b1000, 1'b0);
    cyc("e.idle", 1'b0, 4'b1001, 1'b0, 4'b0000, 1'b0);
    cyc("e.g0",   1'b0, 4'b1001, 1'b0, 4'b0001, 1'b1);

    // burst_len 1: alternating single writes 0,1,0,1
    rst = 1'b1; REQ = 4'b0000; REQ1 = 4'b0011;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc1("f.idle", 4'b0000, 1'b0);
      cyc1("f.wr", (i % 2 == 0) ? 4'b0001 : 4'b0010, 1'b1);
    end
    cyc1("f.gap", 4'b0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gh_fifo_wr_arb4.md
GH_FIFO_WR_ARB4 -- requirements
Module: gh_fifo_wr_arb4

Interface
REQ-001 Parameter data_width, default 8, width of each requester data word and of the FIFO write bus.
REQ-002 Parameter burst_len, default 4, legal range 1..15, maximum writes per grant before forced release.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-005 REQ  input  4  per-requester write request; REQ[i] high means requester i presents valid data on its D_IN slice.
REQ-006 D_IN  input  4*data_width  requester data; slice i = D_IN[(i+1)*data_width-1 : i*data_width].
REQ-007 ACK  output  4  one-hot; ACK[i] high means requester i's current word is written this cycle.
REQ-008 GNT  output  4  one-hot registered owner of the FIFO write port; all zero when idle.
REQ-009 full  input  1  full flag from the downstream FIFO (write side).
REQ-010 WR  output  1  write strobe to the FIFO.
REQ-011 D  output  data_width  write data to the FIFO.
REQ-012 busy  output  1  high while in state GRANT.

Function
REQ-013 The block SHALL implement a two-state FSM: IDLE and GRANT.
REQ-014 In IDLE with any REQ bit high, the block SHALL select the owner by round-robin: search order starts at (last+1) mod 4 and wraps; the first requester with REQ high wins.
REQ-015 On the selection edge, the block SHALL load GNT with the one-hot owner, set last to the owner index, clear the beat counter and enter GRANT.
REQ-016 In IDLE with REQ = 0000, the block SHALL remain in IDLE with GNT = 0000.
REQ-017 WR, D and ACK SHALL be combinational from registered state: WR = GRANT and REQ[owner] and not full and not rst; D = owner data slice; ACK = GNT masked by WR.
REQ-018 When no write occurs, D SHALL present the owner slice in GRANT and all zeros in IDLE.
REQ-019 Each cycle with WR high, the beat counter (4 bits) SHALL increment by 1.
REQ-020 When full is high in GRANT, the block SHALL hold WR and ACK low, keep the beat counter and ownership unchanged, and place no limit on stall length.
REQ-021 On an edge where WR is high and the counter reaches burst_len, the block SHALL return to IDLE and clear GNT.
REQ-022 On an edge where REQ[owner] is low in GRANT, the block SHALL return to IDLE and clear GNT.
REQ-023 After every release there SHALL be exactly one IDLE cycle, with WR low, before the next grant.
REQ-024 Minimum latency from REQ rising in IDLE to the first WR SHALL be 1 cycle: GNT is set at edge n+1 and WR is high during cycle n+1 if full is low.
REQ-025 REQ changes of non-owners during GRANT SHALL NOT affect the current burst.
REQ-026 With all four REQ held high continuously, grant order SHALL be 0,1,2,3,0,...; each owner gets burst_len writes.
REQ-027 busy SHALL equal 1 exactly when the FSM is in GRANT.

Reset
REQ-028 While rst is high, WR SHALL be 0 and ACK SHALL be 0000 combinationally.
REQ-029 At a rst edge the block SHALL enter IDLE with GNT = 0000, busy = 0, beat counter = 0 and last = 3, so that requester 0 has first priority.
REQ-030 A rst assertion in mid-burst SHALL abort the burst; the interrupted requester gets no priority credit.

Verification
REQ-031 Reset, then REQ = 0001 held, full = 0, burst_len = 4 -> GNT = 0001 one cycle later; 4 consecutive WR/ACK[0]; 1 IDLE cycle; then re-grant to 0.
REQ-032 REQ = 1111 held, full = 0 -> GNT sequence 0001, 0010, 0100, 1000, 0001; 4 writes each; one IDLE gap between grants; D matches the owner slice on every WR.
REQ-033 Owner 2 mid-burst, full high for 3 cycles -> WR = 0, ACK = 0000, counter frozen; the burst resumes and totals 4 writes with no loss or duplication.
REQ-034 Owner 1 drops REQ after 2 writes -> release at the next edge; REQ[3] pending -> GNT = 1000 after one IDLE cycle.
REQ-035 rst pulsed during owner 3's second beat -> WR = 0 in the rst cycle; GNT = 0000 after the edge; with REQ = 1001 the next grant goes to requester 0.
REQ-036 burst_len = 1 with REQ = 0011 -> alternating single writes 0, 1, 0, 1, with one IDLE cycle between each.
